// File: rtl/microwave_pkg.sv
// Shared types for the microwave oven timer controller.
package microwave_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OPEN  = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    BELL  = 3'd4
  } mw_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
// clr restarts the count; a disabled prescaler holds its count.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign tick = en && (count_q == LAST);

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Microwave controller: door/start FSM with internal cook-time countdown,
// duty-cycled power, add-time and a timed bell before returning to idle.
module microwave_timer_ctrl
  import microwave_pkg::*;
#(
  parameter int unsigned TIME_W     = 8,
  parameter int unsigned TICK_DIV   = 100,
  parameter int unsigned PWR_LEVELS = 4,
  parameter int unsigned BELL_SEC   = 3,
  parameter int unsigned ADD_STEP   = 30,
  localparam int unsigned PW        = $clog2(PWR_LEVELS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              door,
  input  logic              start,
  input  logic              stop,
  input  logic              add,
  input  logic              time_load,
  input  logic [TIME_W-1:0] time_in,
  input  logic [PW-1:0]     power_in,
  output logic              heat,
  output logic              light,
  output logic              bell,
  output logic [TIME_W-1:0] remaining,
  output logic              busy
);

  localparam int unsigned BW = (BELL_SEC > 1) ? $clog2(BELL_SEC) : 1;
  localparam logic [TIME_W-1:0] T_MAX     = '1;
  localparam logic [TIME_W:0]   ADD_W     = (TIME_W + 1)'(ADD_STEP);
  localparam logic [PW-1:0]     P_MAX     = PW'(PWR_LEVELS);
  localparam logic [PW-1:0]     PH_LAST   = PW'(PWR_LEVELS - 1);
  localparam logic [BW-1:0]     BELL_LAST = BW'(BELL_SEC - 1);

  mw_state_t         state_q, state_d;
  logic [TIME_W-1:0] rem_q, rem_d;
  logic [PW-1:0]     power_q, power_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [BW-1:0]     bell_cnt_q, bell_cnt_d;
  logic              presc_en, presc_clr, tick;
  logic [TIME_W:0]   add_sum;
  logic [PW-1:0]     phase_next;

  // Gating the prescaler on door keeps the partial second frozen across a pause.
  assign presc_en = ((state_q == COOK) && !door) || (state_q == BELL);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (presc_en),
    .clr  (presc_clr),
    .tick (tick)
  );

  always_comb begin
    add_sum    = {1'b0, rem_q} + ADD_W - {{TIME_W{1'b0}}, tick};
    phase_next = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    power_d    = power_q;
    phase_d    = phase_q;
    bell_cnt_d = bell_cnt_q;
    presc_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (door) begin
          state_d = OPEN;
        end else if (stop) begin
          rem_d = '0;
        end else if (time_load) begin
          rem_d = time_in;
        end else if (start && (rem_q != '0)) begin
          state_d   = COOK;
          power_d   = (power_in > P_MAX) ? P_MAX : power_in;
          phase_d   = '0;
          presc_clr = 1'b1;
        end
      end
      OPEN: begin
        if (!door) begin
          state_d = IDLE;
        end else if (stop) begin
          rem_d = '0;
        end else if (time_load) begin
          rem_d = time_in;
        end
      end
      COOK: begin
        if (door) begin
          state_d = PAUSE;
        end else if (stop) begin
          state_d = IDLE;
          rem_d   = '0;
        end else if (add) begin
          rem_d = add_sum[TIME_W] ? T_MAX : add_sum[TIME_W-1:0];
          if (tick) phase_d = phase_next;
        end else if (tick && (rem_q != '0)) begin
          rem_d   = rem_q - TIME_W'(1);
          phase_d = phase_next;
          if (rem_q == TIME_W'(1)) begin
            state_d    = BELL;
            bell_cnt_d = '0;
            presc_clr  = 1'b1;
          end
        end
      end
      PAUSE: begin
        if (!door) begin
          state_d = COOK;
        end else if (stop) begin
          state_d = OPEN;
          rem_d   = '0;
        end
      end
      BELL: begin
        if (door) begin
          state_d = OPEN;
        end else if (stop || start) begin
          state_d = IDLE;
        end else if (tick) begin
          if (bell_cnt_q == BELL_LAST) state_d = IDLE;
          else                         bell_cnt_d = bell_cnt_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      power_q    <= '0;
      phase_q    <= '0;
      bell_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      power_q    <= power_d;
      phase_q    <= phase_d;
      bell_cnt_q <= bell_cnt_d;
    end
  end

  assign heat      = (state_q == COOK) && (phase_q < power_q);
  assign light     = (state_q == OPEN) || (state_q == COOK) || (state_q == PAUSE);
  assign bell      = (state_q == BELL);
  assign busy      = (state_q == COOK) || (state_q == PAUSE);
  assign remaining = rem_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed, table-driven bench for microwave_timer_ctrl with a fast tick.
module tb_microwave_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst, door, start, stop, add, time_load;
  logic [7:0] time_in;
  logic [2:0] power_in;
  logic       heat, light, bell, busy;
  logic [7:0] remaining;

  int n_chk  = 0;
  int n_fail = 0;

  microwave_timer_ctrl #(
    .TIME_W(8), .TICK_DIV(4), .PWR_LEVELS(4), .BELL_SEC(3), .ADD_STEP(30)
  ) dut (
    .clk(clk), .rst(rst), .door(door), .start(start), .stop(stop), .add(add),
    .time_load(time_load), .time_in(time_in), .power_in(power_in),
    .heat(heat), .light(light), .bell(bell), .remaining(remaining), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic       door, start, stop, add, tl;
    logic [7:0] tin;
    logic [2:0] pin;
    int         n;
    logic [11:0] ex;
  } vec_t;

  vec_t vq[$];

  function automatic logic [11:0] e(logic h, logic l, logic b, logic bz, logic [7:0] r);
    return {h, l, b, bz, r};
  endfunction

  function automatic vec_t mk(string nm, logic d, logic s, logic sp, logic a, logic tl,
                              logic [7:0] tin, logic [2:0] pin, int n, logic [11:0] ex);
    vec_t v;
    v.nm = nm; v.door = d; v.start = s; v.stop = sp; v.add = a; v.tl = tl;
    v.tin = tin; v.pin = pin; v.n = n; v.ex = ex;
    return v;
  endfunction

  function automatic logic [11:0] obs();
    return {heat, light, bell, busy, remaining};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    start = 0; stop = 0; add = 0; time_load = 0;
  endtask

  int  cnt;
  logic got_bell;

  initial begin
    rst = 1; door = 0; time_in = '0; power_in = '0;
    clear_pulses();

    //        name            door st sp ad tl tin  pin n   {heat,light,bell,busy,rem}
    vq.push_back(mk("t1_load",     0, 0, 0, 0, 1, 3,   0, 1,  e(0,0,0,0,3)));
    vq.push_back(mk("t1_start",    0, 1, 0, 0, 0, 0,   4, 1,  e(1,1,0,1,3)));
    vq.push_back(mk("t1_sec0_end", 0, 0, 0, 0, 0, 0,   0, 3,  e(1,1,0,1,3)));
    vq.push_back(mk("t1_sec1",     0, 0, 0, 0, 0, 0,   0, 1,  e(1,1,0,1,2)));
    vq.push_back(mk("t1_last_sec", 0, 0, 0, 0, 0, 0,   0, 7,  e(1,1,0,1,1)));
    vq.push_back(mk("t1_bell",     0, 0, 0, 0, 0, 0,   0, 1,  e(0,0,1,0,0)));
    vq.push_back(mk("t1_bell_end", 0, 0, 0, 0, 0, 0,   0, 11, e(0,0,1,0,0)));
    vq.push_back(mk("t1_idle",     0, 0, 0, 0, 0, 0,   0, 1,  e(0,0,0,0,0)));
    vq.push_back(mk("t2_load",     0, 0, 0, 0, 1, 8,   0, 1,  e(0,0,0,0,8)));
    vq.push_back(mk("t2_start",    0, 1, 0, 0, 0, 0,   2, 1,  e(1,1,0,1,8)));
    vq.push_back(mk("t2_ph0",      0, 0, 0, 0, 0, 0,   0, 3,  e(1,1,0,1,8)));
    vq.push_back(mk("t2_ph1",      0, 0, 0, 0, 0, 0,   0, 4,  e(1,1,0,1,7)));
    vq.push_back(mk("t2_ph2",      0, 0, 0, 0, 0, 0,   0, 4,  e(0,1,0,1,6)));
    vq.push_back(mk("t2_ph3",      0, 0, 0, 0, 0, 0,   0, 4,  e(0,1,0,1,5)));
    vq.push_back(mk("t2_ph0b",     0, 0, 0, 0, 0, 0,   0, 4,  e(1,1,0,1,4)));
    vq.push_back(mk("t2_ph1b",     0, 0, 0, 0, 0, 0,   0, 4,  e(1,1,0,1,3)));
    vq.push_back(mk("t2_ph2b",     0, 0, 0, 0, 0, 0,   0, 4,  e(0,1,0,1,2)));
    vq.push_back(mk("t2_stop",     0, 0, 1, 0, 0, 0,   0, 1,  e(0,0,0,0,0)));
    vq.push_back(mk("t5_start0",   0, 1, 0, 0, 0, 0,   4, 1,  e(0,0,0,0,0)));
    vq.push_back(mk("t5_open",     1, 0, 0, 0, 0, 0,   0, 1,  e(0,1,0,0,0)));
    vq.push_back(mk("t5_open_ld",  1, 0, 0, 0, 1, 5,   0, 1,  e(0,1,0,0,5)));
    vq.push_back(mk("t5_open_st",  1, 1, 0, 0, 0, 0,   4, 1,  e(0,1,0,0,5)));
    vq.push_back(mk("t5_open_sp",  1, 0, 1, 0, 0, 0,   0, 1,  e(0,1,0,0,0)));
    vq.push_back(mk("t5_open_ld2", 1, 0, 0, 0, 1, 250, 0, 1,  e(0,1,0,0,250)));
    vq.push_back(mk("t5_close",    0, 0, 0, 0, 0, 0,   0, 1,  e(0,0,0,0,250)));
    vq.push_back(mk("t4_start_p7", 0, 1, 0, 0, 0, 0,   7, 1,  e(1,1,0,1,250)));
    vq.push_back(mk("t4_add_sat",  0, 0, 0, 1, 0, 0,   0, 1,  e(1,1,0,1,255)));
    vq.push_back(mk("t4_add_sat2", 0, 0, 0, 1, 0, 0,   0, 1,  e(1,1,0,1,255)));
    vq.push_back(mk("t4_tick",     0, 0, 0, 0, 0, 0,   0, 3,  e(1,1,0,1,254)));
    vq.push_back(mk("t4_stop",     0, 0, 1, 0, 0, 0,   0, 1,  e(0,0,0,0,0)));
    vq.push_back(mk("t6_load",     0, 0, 0, 0, 1, 9,   0, 1,  e(0,0,0,0,9)));
    vq.push_back(mk("t6_idle_stop",0, 0, 1, 0, 0, 0,   0, 1,  e(0,0,0,0,0)));

    step(); step();
    rst = 0;
    chk("reset_state", 32'(obs()), 32'(e(0,0,0,0,0)));

    foreach (vq[i]) begin
      door = vq[i].door; start = vq[i].start; stop = vq[i].stop; add = vq[i].add;
      time_load = vq[i].tl; time_in = vq[i].tin; power_in = vq[i].pin;
      step();
      clear_pulses();
      for (int k = 1; k < vq[i].n; k++) step();
      chk(vq[i].nm, 32'(obs()), 32'(vq[i].ex));
    end
    door = 0;

    // Pause: door open for 10 cycles; heat-on cycles with the door shut must total 20.
    time_load = 1; time_in = 5; step(); clear_pulses();
    start = 1; power_in = 4; step(); clear_pulses();
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      if (bell) break;
      door = (k >= 2) && (k < 12);
      if (k >= 3 && k <= 12) chk("pause_out", 32'(obs()), 32'(e(0,1,0,1,5)));
      if (!door && heat) cnt++;
      step();
    end
    door = 0;
    got_bell = bell;
    chk("pause_bell_reached", 32'(got_bell), 32'd1);
    chk("pause_heat_cycles", 32'(cnt), 32'd20);
    for (int k = 0; k < 20; k++) begin
      if (!bell) break;
      step();
    end
    chk("pause_end_idle", 32'(obs()), 32'(e(0,0,0,0,0)));

    // Add on the same cycle as a tick: 2 + 30 - 1.
    time_load = 1; time_in = 2; step(); clear_pulses();
    start = 1; power_in = 4; step(); clear_pulses();
    step(); step(); step();
    chk("addtick_pre", 32'(obs()), 32'(e(1,1,0,1,2)));
    add = 1; step(); clear_pulses();
    chk("addtick_net", 32'(obs()), 32'(e(1,1,0,1,31)));
    step(); step(); step(); step();
    chk("addtick_next_sec", 32'(obs()), 32'(e(1,1,0,1,30)));
    stop = 1; step(); clear_pulses();
    chk("addtick_stop", 32'(obs()), 32'(e(0,0,0,0,0)));

    // Door during the bell cuts it and opens.
    time_load = 1; time_in = 1; step(); clear_pulses();
    start = 1; power_in = 4; step(); clear_pulses();
    step(); step(); step(); step();
    chk("bell_entry", 32'(obs()), 32'(e(0,0,1,0,0)));
    door = 1; step();
    chk("bell_door_open", 32'(obs()), 32'(e(0,1,0,0,0)));
    door = 0; step();

    // Reset mid-cook.
    time_load = 1; time_in = 7; step(); clear_pulses();
    start = 1; power_in = 4; step(); clear_pulses();
    step(); step(); step(); step(); step();
    chk("midcook_busy", 32'(obs()), 32'(e(1,1,0,1,6)));
    rst = 1; step(); rst = 0;
    chk("midcook_reset", 32'(obs()), 32'(e(0,0,0,0,0)));
    for (int k = 0; k < 6; k++) step();
    chk("midcook_stay_idle", 32'(obs()), 32'(e(0,0,0,0,0)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
